// File: rtl/knn_dma_s2mm.sv
// knn_dma_s2mm: AXI4-Stream to AXI4 memory write engine for the KNN DMA.
// Stream beats are collected into a BURST_LEN-deep buffer. Each buffer fill is
// written out as one INCR burst (AW, then W, then B). The upstream stream is
// stalled while a burst is in flight.
module knn_dma_s2mm #(
  parameter int BURST_LEN  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  INIT_TXN,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [15:0]           XFER_LEN,
  output logic                  TXN_DONE,
  output logic                  ERROR,
  output logic [15:0]           BEATS_WRITTEN,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  S_AXIS_TLAST,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  localparam int IW = $clog2(BURST_LEN);
  localparam int CW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_init_q;
  logic [DATA_WIDTH-1:0] r_buf [BURST_LEN];
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_rd;
  logic [15:0]           r_remaining;
  logic [15:0]           r_beats;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_awlen;
  logic                  r_last_seen;
  logic                  r_error;

  logic                  w_start;
  logic                  w_accept;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_fill_end;
  logic                  w_wlast;
  logic                  w_resp_done;

  assign w_start     = INIT_TXN & ~r_init_q;
  assign w_accept    = S_AXIS_TVALID & (r_state == S_FILL);
  assign w_cnt_inc   = r_cnt + CW'(1);
  // A full buffer, an exhausted length and TLAST all close the burst; any
  // combination of them on one beat is a single event.
  assign w_fill_end  = w_accept & ((w_cnt_inc == CW'(BURST_LEN)) |
                                   (16'(w_cnt_inc) == r_remaining) |
                                   S_AXIS_TLAST);
  assign w_wlast     = ({1'b0, r_rd} == (r_cnt - CW'(1)));
  assign w_resp_done = (r_remaining == 16'(r_cnt)) | r_last_seen;

  assign TXN_DONE      = (r_state == S_DONE);
  assign ERROR         = r_error;
  assign BEATS_WRITTEN = r_beats;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WDATA   = r_buf[r_rd];
  assign M_AXI_WLAST   = (r_state == S_DATA) & w_wlast;

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next        = r_state;
    S_AXIS_TREADY = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) w_next = (XFER_LEN == 16'd0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        S_AXIS_TREADY = 1'b1;
        if (w_fill_end) w_next = S_ADDR;
      end
      S_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) w_next = S_DATA;
      end
      S_DATA: begin
        M_AXI_WVALID = 1'b1;
        if (M_AXI_WREADY && w_wlast) w_next = S_RESP;
      end
      S_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) w_next = S_DONE;
          else if (w_resp_done)     w_next = S_DONE;
          else                      w_next = S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: counters, address, status
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_init_q    <= 1'b0;
      r_cnt       <= '0;
      r_rd        <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_addr      <= '0;
      r_awlen     <= '0;
      r_last_seen <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_init_q <= INIT_TXN;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_error     <= 1'b0;
            r_beats     <= '0;
            r_addr      <= BASE_ADDR;
            r_remaining <= XFER_LEN;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_last_seen <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (w_fill_end) begin
              r_last_seen <= S_AXIS_TLAST;
              r_awlen     <= 8'(r_cnt);
            end
          end
        end
        S_DATA: begin
          if (M_AXI_WREADY) r_rd <= r_rd + IW'(1);
        end
        S_RESP: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != 2'b00) begin
              r_error <= 1'b1;
            end else begin
              r_beats     <= r_beats + 16'(r_cnt);
              r_remaining <= r_remaining - 16'(r_cnt);
              r_addr      <= r_addr + (ADDR_WIDTH'(r_cnt) << 2);
              r_cnt       <= '0;
              r_rd        <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Burst buffer capture; contents need no reset
  always_ff @(posedge ACLK) begin
    if (w_accept) r_buf[r_cnt[IW-1:0]] <= S_AXIS_TDATA;
  end

endmodule
